pwm_breather: RTL and testbench

PWM_BREATHER -- requirements
Module: pwm_breather

---
 rtl/led_pkg.sv | 26 ++
 rtl/breath_chan.sv | 105 ++++++++++
 rtl/pwm_breather.sv | 107 ++++++++++
 tb/tb_pwm_breather.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
// Shared constants for the PWM breathing LED controller.
//   mode_e    : per-channel output mode (OFF, ON, FIXED duty, BREATHE)
//   breath_e  : breath FSM direction (UP, DOWN)
//   div_width : register width for a 0..n-1 counter (never below 1 bit)
// ----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_FIXED   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic {
        BR_UP   = 1'b0,
        BR_DOWN = 1'b1
    } breath_e;

    function automatic int div_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/breath_chan.sv
// ----------------------------------------------------------------------------
// breath_chan
// One LED channel: triangle-wave breath level FSM, optional square-law
// gamma correction, and the PWM compare that yields the next o_led value.
//   i_clk     : clock
//   i_reset   : asynchronous active-high reset (level -> RST_LVL, state UP)
//   i_tick    : breath step strobe, one cycle, coincident with counter wrap
//   i_cnt     : shared PWM counter
//   i_mode    : shadowed channel mode
//   i_duty    : shadowed channel fixed duty
//   o_led_d   : next value of this channel's registered LED output
// ----------------------------------------------------------------------------
module breath_chan
    import led_pkg::*;
#(
    parameter int              PW      = 8,
    parameter int              GAMMA   = 1,
    parameter logic [PW-1:0]   RST_LVL = '0
)(
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_tick,
    input  logic [PW-1:0] i_cnt,
    input  mode_e         i_mode,
    input  logic [PW-1:0] i_duty,
    output logic          o_led_d
);

    localparam logic [PW-1:0] LVL_MAX = '1;
    localparam logic [PW-1:0] LVL_TOP = LVL_MAX - PW'(1);

    breath_e       state_q, state_d;
    logic [PW-1:0] lvl_q, lvl_d;
    logic [PW-1:0] eff;
    logic [PW-1:0] cmp;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= BR_UP;
            lvl_q   <= RST_LVL;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
        end
    end

    // Next state: the level turns around at the end stops instead of
    // wrapping; the >=/<= comparisons also catch a reset level that starts
    // at full scale.
    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        if (i_tick) begin
            case (state_q)
                BR_UP: begin
                    if (lvl_q >= LVL_TOP) begin
                        state_d = BR_DOWN;
                        lvl_d   = LVL_MAX;
                    end else begin
                        lvl_d   = lvl_q + PW'(1);
                    end
                end
                BR_DOWN: begin
                    if (lvl_q <= PW'(1)) begin
                        state_d = BR_UP;
                        lvl_d   = '0;
                    end else begin
                        lvl_d   = lvl_q - PW'(1);
                    end
                end
                default: begin
                    state_d = BR_UP;
                end
            endcase
        end
    end

    // Effective level: upper half of L*L when gamma is on
    if (GAMMA != 0) begin : g_gamma
        assign eff = PW'(({{PW{1'b0}}, lvl_q} * {{PW{1'b0}}, lvl_q}) >> PW);
    end else begin : g_linear
        assign eff = lvl_q;
    end

    // Output: compare level selection and PWM compare
    always_comb begin
        cmp     = '0;
        o_led_d = 1'b0;
        case (i_mode)
            MODE_OFF:     o_led_d = 1'b0;
            MODE_ON:      o_led_d = 1'b1;
            MODE_FIXED: begin
                cmp     = i_duty;
                o_led_d = (i_cnt < cmp);
            end
            MODE_BREATHE: begin
                cmp     = eff;
                o_led_d = (i_cnt < cmp);
            end
            default:      o_led_d = 1'b0;
        endcase
    end

endmodule

// File: rtl/pwm_breather.sv
// ----------------------------------------------------------------------------
// pwm_breather
// Multi-channel PWM LED driver with per-channel OFF/ON/FIXED/BREATHE modes.
// A shared PW-bit counter sets the PWM period (2^PW cycles); mode and duty
// are shadowed at the period boundary so outputs never glitch mid-period.
//   Parameters: NCH channels, PW counter bits, BDIV periods per breath step,
//               GAMMA (1 = square-law breath level, 0 = linear)
//   i_clk   : clock
//   i_reset : asynchronous active-high reset
//   i_mode  : 2 bits per channel, channel k at [2k+1:2k]
//   i_duty  : PW bits per channel, channel k at [PW*k+PW-1:PW*k]
//   o_led   : registered PWM outputs, one per channel
//   o_sync  : one-cycle pulse aligned with o_led of counter value 0
// ----------------------------------------------------------------------------
module pwm_breather
    import led_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int PW    = 8,
    parameter int BDIV  = 4,
    parameter int GAMMA = 1
)(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [2*NCH-1:0]    i_mode,
    input  logic [PW*NCH-1:0]   i_duty,
    output logic [NCH-1:0]      o_led,
    output logic                o_sync
);

    localparam int              DIV_W    = div_width(BDIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BDIV - 1);
    localparam logic [PW-1:0]   CNT_MAX  = '1;

    logic [PW-1:0]      cnt_q,   cnt_d;
    logic [DIV_W-1:0]   div_q,   div_d;
    logic [2*NCH-1:0]   smode_q, smode_d;
    logic [PW*NCH-1:0]  sduty_q, sduty_d;
    logic [NCH-1:0]     led_q,   led_d;
    logic               sync_q,  sync_d;

    logic               wrap;
    logic               tick;

    assign wrap = (cnt_q == CNT_MAX);
    assign tick = wrap && (div_q == DIV_LAST);

    always_comb begin
        cnt_d   = cnt_q + PW'(1);
        div_d   = div_q;
        smode_d = smode_q;
        sduty_d = sduty_q;
        // Shadow load and divider advance only on the last counter value,
        // so the new settings take effect exactly at counter 0.
        if (wrap) begin
            div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            smode_d = i_mode;
            sduty_d = i_duty;
        end
    end

    // o_led reflects the previous counter value, so o_sync registers
    // "counter was 0" to stay aligned with it.
    assign sync_d = (cnt_q == '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q   <= '0;
            div_q   <= '0;
            smode_q <= '0;
            sduty_q <= '0;
            led_q   <= '0;
            sync_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            smode_q <= smode_d;
            sduty_q <= sduty_d;
            led_q   <= led_d;
            sync_q  <= sync_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        // Staggered start level k*2^PW/NCH spreads the channels' phases.
        localparam longint        RST_FULL = (longint'(k) << PW) / longint'(NCH);
        localparam logic [PW-1:0] RST_LVL  = PW'(RST_FULL);

        breath_chan #(
            .PW      (PW),
            .GAMMA   (GAMMA),
            .RST_LVL (RST_LVL)
        ) u_chan (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_tick  (tick),
            .i_cnt   (cnt_q),
            .i_mode  (mode_e'(smode_q[2*k +: 2])),
            .i_duty  (sduty_q[PW*k +: PW]),
            .o_led_d (led_d[k])
        );
    end

    assign o_led  = led_q;
    assign o_sync = sync_q;

endmodule

// File: tb/tb_pwm_breather.sv
// ----------------------------------------------------------------------------
// tb_pwm_breather
// Drives two pwm_breather instances (GAMMA=0 and GAMMA=1) with shared
// stimulus. A behavioural model pushes each cycle's expected outputs to a
// scoreboard queue; they are popped and compared after the clock edge.
// Per-period high counts are also checked against hand-computed values.
// ----------------------------------------------------------------------------
module tb_pwm_breather;

    localparam int NCH  = 4;
    localparam int PW   = 4;
    localparam int BDIV = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic                clk;
    logic                i_reset;
    logic [2*NCH-1:0]    i_mode;
    logic [PW*NCH-1:0]   i_duty;
    logic [NCH-1:0]      o_led, o_led_g;
    logic                o_sync, o_sync_g;

    pwm_breather #(.NCH(NCH), .PW(PW), .BDIV(BDIV), .GAMMA(0)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_mode(i_mode), .i_duty(i_duty),
        .o_led(o_led), .o_sync(o_sync)
    );

    pwm_breather #(.NCH(NCH), .PW(PW), .BDIV(BDIV), .GAMMA(1)) dut_g (
        .i_clk(clk), .i_reset(i_reset), .i_mode(i_mode), .i_duty(i_duty),
        .o_led(o_led_g), .o_sync(o_sync_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] led;
        logic [NCH-1:0] ledg;
        logic           sync;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int m_cnt, m_div;
    int m_smode[NCH];
    int m_sduty[NCH];
    int m_lvl[NCH];
    int m_dir[NCH];

    // period statistics from sampled DUT outputs
    logic s_sync;
    int   run[NCH], run_g[NCH], last_per[NCH], last_g[NCH];
    int   since_sync, last_gap;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_div = 0;
        for (int k = 0; k < NCH; k++) begin
            m_smode[k] = 0;
            m_sduty[k] = 0;
            m_lvl[k]   = (k * (PMAX + 1)) / NCH;
            m_dir[k]   = 1;
        end
    endtask

    function automatic bit model_led(input int k, input bit gam);
        int e;
        e = gam ? ((m_lvl[k] * m_lvl[k]) >> PW) : m_lvl[k];
        case (m_smode[k])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return m_cnt < m_sduty[k];
            default: return m_cnt < e;
        endcase
    endfunction

    // One clock: predict, push, advance model, clock, pop and compare.
    task automatic step();
        exp_t e;
        exp_t got;
        e.led  = '0;
        e.ledg = '0;
        e.sync = 1'b0;
        if (!i_reset) begin
            e.sync = (m_cnt == 0);
            for (int k = 0; k < NCH; k++) begin
                e.led[k]  = model_led(k, 1'b0);
                e.ledg[k] = model_led(k, 1'b1);
            end
        end
        sb.push_back(e);

        if (i_reset) begin
            model_reset();
        end else begin
            if (m_cnt == PMAX) begin
                if (m_div == BDIV - 1) begin
                    for (int k = 0; k < NCH; k++) begin
                        m_lvl[k] += m_dir[k];
                        if (m_lvl[k] == PMAX) m_dir[k] = -1;
                        if (m_lvl[k] == 0)    m_dir[k] = 1;
                    end
                end
                m_div = (m_div + 1) % BDIV;
                for (int k = 0; k < NCH; k++) begin
                    m_smode[k] = int'(i_mode[2*k +: 2]);
                    m_sduty[k] = int'(i_duty[PW*k +: PW]);
                end
            end
            m_cnt = (m_cnt + 1) % (PMAX + 1);
        end

        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_val("led",    32'(o_led),    32'(got.led));
        check_val("led_g",  32'(o_led_g),  32'(got.ledg));
        check_val("sync",   32'(o_sync),   32'(got.sync));
        check_val("sync_g", 32'(o_sync_g), 32'(got.sync));

        s_sync = o_sync;
        if (o_sync) begin
            last_gap   = since_sync;
            since_sync = 1;
            for (int k = 0; k < NCH; k++) begin
                last_per[k] = run[k];
                last_g[k]   = run_g[k];
                run[k]      = int'(o_led[k]);
                run_g[k]    = int'(o_led_g[k]);
            end
        end else begin
            since_sync++;
            for (int k = 0; k < NCH; k++) begin
                run[k]   += int'(o_led[k]);
                run_g[k] += int'(o_led_g[k]);
            end
        end
    endtask

    task automatic wait_sync();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!s_sync && n < 40);
        if (!s_sync) check_val("sync_timeout", 32'd0, 32'd1);
    endtask

    task automatic seek_cnt(input int target);
        int n;
        n = 0;
        while (m_cnt != target && n < 40) begin
            step();
            n++;
        end
        if (m_cnt != target) check_val("cnt_seek", 32'(m_cnt), 32'(target));
    endtask

    task automatic check_per(input string tag, input bit gam,
                             input int e0, input int e1, input int e2, input int e3);
        int ex[NCH];
        ex = '{e0, e1, e2, e3};
        for (int k = 0; k < NCH; k++) begin
            if (gam) check_val($sformatf("%s_g_ch%0d", tag, k), 32'(last_g[k]), 32'(ex[k]));
            else     check_val($sformatf("%s_ch%0d", tag, k),   32'(last_per[k]), 32'(ex[k]));
        end
    endtask

    // Release reset with BREATHE on all channels and check the first
    // breathing periods use the staggered reset levels.
    task automatic breathe_from_reset();
        i_mode = 8'hFF;
        step();
        step();
        i_reset = 1'b0;
        wait_sync();                              // P0 (shadow still OFF)
        wait_sync();
        check_per("br_p0", 1'b0, 0, 0, 0, 0);
        wait_sync();
        check_per("br_p1", 1'b0, 0, 4, 8, 12);
        check_per("br_p1", 1'b1, 0, 1, 4, 9);
    endtask

    initial begin
        i_reset    = 1'b1;
        i_mode     = '0;
        i_duty     = '0;
        s_sync     = 1'b0;
        since_sync = 0;
        last_gap   = 0;
        for (int k = 0; k < NCH; k++) begin
            run[k] = 0; run_g[k] = 0; last_per[k] = 0; last_g[k] = 0;
        end
        model_reset();

        // Reset state
        #1;
        check_val("rst_led",  32'(o_led),  32'd0);
        check_val("rst_sync", 32'(o_sync), 32'd0);

        // FIXED duty 5 on every channel
        i_mode = 8'hAA;
        i_duty = 16'h5555;
        step();
        step();
        step();
        i_reset = 1'b0;
        wait_sync();
        wait_sync();
        check_per("fix_p0", 1'b0, 0, 0, 0, 0);
        wait_sync();
        check_per("fix5", 1'b0, 5, 5, 5, 5);
        check_val("sync_gap", 32'(last_gap), 32'd16);

        // Duty change mid-period only affects the following period
        seek_cnt(7);
        i_duty = 16'h555C;
        wait_sync();
        check_per("dchg_cur", 1'b0, 5, 5, 5, 5);
        wait_sync();
        check_per("dchg_nxt", 1'b0, 12, 5, 5, 5);
        check_val("sync_gap2", 32'(last_gap), 32'd16);

        // Breathing from reset levels, then gamma checks at ch3 L=15, ch0 L=3
        i_reset = 1'b1;
        #1;
        breathe_from_reset();
        wait_sync();
        check_per("br_p2", 1'b0, 1, 5, 9, 13);
        repeat (4) wait_sync();
        check_per("br_p6", 1'b0, 3, 7, 11, 15);
        check_val("gam_l15", 32'(last_g[3]), 32'd14);
        check_val("gam_l3",  32'(last_g[0]), 32'd0);

        // Full up/down walk covered by the per-cycle scoreboard
        repeat (1000) step();

        // ON / OFF
        i_mode = 8'h11;
        wait_sync();
        wait_sync();
        check_per("onoff", 1'b0, 16, 0, 16, 0);
        check_per("onoff", 1'b1, 16, 0, 16, 0);

        // Reset mid-period: outputs clear immediately, levels restart
        seek_cnt(9);
        i_reset = 1'b1;
        #1;
        check_val("arst_led",   32'(o_led),   32'd0);
        check_val("arst_led_g", 32'(o_led_g), 32'd0);
        check_val("arst_sync",  32'(o_sync),  32'd0);
        breathe_from_reset();
        check_val("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
